crypto_wallet_gpio_in_conditioner: RTL and testbench
====================================================

# crypto_wallet_gpio_in_conditioner

Input conditioning stage between the wallet's external button/switch pins and the 32-bit GPIO PIO's input path. Each pin is synchronised, debounced with a per-bit stability counter, and edge-captured; the debounced vector drives the PIO data-in path. A small Avalon-MM slave register file exposes the state, and a maskable interrupt reports captured edges to the Nios.

## Interface
Parameters:
- WIDTH, 32: number of conditioned pins, 1..32.
- DEBOUNCE_CYCLES, 50000: consecutive clk cycles a changed level must persist before acceptance, >= 2. Counter width is $clog2(DEBOUNCE_CYCLES).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- pin_in  in  WIDTH  raw asynchronous pin levels.
- cond_out  out  WIDTH  debounced stable levels, feeds PIO data-in.
- address  in  2  Avalon word address.
- chipselect  in  1  Avalon select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- irq  out  1  active-high interrupt, level.

## Operation
- Sync: two-flop synchroniser per bit, sync1 <= pin_in, sync2 <= sync1.
- Debounce, per bit: if sync2 == stable, counter <= 0. Else if counter == DEBOUNCE_CYCLES-1, stable <= sync2 and counter <= 0. Else counter <= counter+1. Any bounce back to the stable level clears the counter. cond_out = stable.
- Edge capture: edge[i] is set on the cycle stable[i] changes 0->1. Falling changes are captured only per Configuration.
- Register map (word addresses):
  - 0: stable, read-only.
  - 1: edge capture. Writing 1 to a bit clears it; writing 0 has no effect.
  - 2: irq mask, read/write, bits [WIDTH-1:0].
  - 3: sync2 raw synchronised level, read-only.
- Writes to addresses 0 and 3 are ignored. A write occurs when chipselect && !write_n.
- Read: readdata <= mux(address) every clk, independent of chipselect. Bits [31:WIDTH] read 0.
- irq = |(edge & mask), driven combinationally from registers only.
- Simultaneous edge set and write-1-clear on the same bit: the set wins and the bit stays 1.
- Mask write and edge set in the same cycle: both take effect.

## Timing
- Reset values: sync1, sync2, stable, counters, edge and mask all 0. Outputs: cond_out=0, readdata=0, irq=0.
- A pin held high through reset release appears as a rising edge DEBOUNCE_CYCLES+2 clks later.
- Latency: pin_in settles before clk edge 1; stable/cond_out updates at edge DEBOUNCE_CYCLES+2. edge[i] is set at the same edge, and irq asserts in that cycle if the bit is masked.
- Read latency is 1 clk: readdata reflects the address presented at the previous edge.
- Register writes take effect at the clk edge of the write. irq deasserts in the cycle after the clearing edge.
- Asserting reset_n mid-debounce aborts the count: all state returns to reset values immediately, with no edge recorded.

## Configuration
- GPIO_COND_FALL_EDGE_EN defined: edge[i] is set on any stable[i] change, rising or falling.
- Undefined: only rising (0->1) changes set edge[i]. Falling changes update stable/cond_out but never touch edge.

## Test plan
All scenarios use WIDTH=4 and DEBOUNCE_CYCLES=4.
- Reset: assert reset_n=0 with pin_in=4'hF. Required: cond_out=0, readdata=0, irq=0. After release, cond_out=4'hF exactly 6 clks later, and edge=4'hF.
- Bounce rejection: pin_in[0] toggles 0->1 for 3 clks, back to 0 for 1 clk, then 1 held. Required: cond_out[0] rises only 6 clks after the final 0->1; no earlier edge.
- IRQ path: mask=4'h2, debounced rise on bit 1. Required: irq=1 in the cycle edge[1] sets. Then write 4'h2 to address 1: edge reads 0 and irq=0 on the next cycle.
- Set beats clear: issue the write-1-clear of bit 2 on the same edge bit 2's debounced rise lands. Required: edge[2]=1 afterwards.
- Readback: write 4'hA to mask and 4'h5 to address 0; read addresses 0..3 each one clk later. Required: address 0 unchanged, mask reads 32'h0000000A, upper 28 bits 0.
- Falling edge: debounced 1->0 on bit 3. Required: with GPIO_COND_FALL_EDGE_EN, edge[3]=1; without it, edge[3]=0 while cond_out[3]=0.

Source files
------------

// File: rtl/crypto_wallet_gpio_in_conditioner_if.sv
// ---------------------------------------------------------------------------
// crypto_wallet_gpio_in_conditioner_if
//
// Avalon-MM slave bus bundle for the GPIO input conditioner register file.
//   address    [1:0]  word address
//   chipselect        slave select
//   write_n           active-low write strobe
//   writedata  [31:0] write data
//   readdata   [31:0] registered read data (slave -> master)
//   irq               level interrupt (slave -> master)
// Modports: master (Nios side / testbench), slave (conditioner).
// ---------------------------------------------------------------------------
interface crypto_wallet_gpio_in_conditioner_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata,
        input  irq
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata,
        output irq
    );
endinterface

// File: rtl/crypto_wallet_gpio_in_conditioner.sv
// ---------------------------------------------------------------------------
// crypto_wallet_gpio_in_conditioner
//
// Conditions the wallet's button/switch pins before the GPIO PIO input path:
// two-flop synchroniser, per-bit stability-counter debounce, and edge capture
// with a maskable level interrupt. A small Avalon-MM register file exposes
// the state.
//
// Parameters:
//   WIDTH            number of conditioned pins (1..32)
//   DEBOUNCE_CYCLES  cycles a changed level must persist before acceptance (>=2)
//
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   pin_in    raw asynchronous pin levels
//   cond_out  debounced stable levels (PIO data-in)
//   bus       Avalon-MM slave (address/chipselect/write_n/writedata/readdata/irq)
//
// Register map (word address):
//   0 stable (RO)   1 edge capture (W1C)   2 irq mask (RW)   3 sync2 raw (RO)
//
// Build option: define GPIO_COND_FALL_EDGE_EN to capture falling as well as
// rising debounced changes; by default only rising changes are captured.
// ---------------------------------------------------------------------------
module crypto_wallet_gpio_in_conditioner #(
    parameter int WIDTH           = 32,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic [WIDTH-1:0]                       pin_in,
    output logic [WIDTH-1:0]                       cond_out,
    crypto_wallet_gpio_in_conditioner_if.slave     bus
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_STABLE = 2'd0;
    localparam logic [1:0] ADDR_EDGE   = 2'd1;
    localparam logic [1:0] ADDR_MASK   = 2'd2;
    localparam logic [1:0] ADDR_SYNC   = 2'd3;

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_stable;
    logic [CW-1:0]    r_cnt [WIDTH];
    logic [WIDTH-1:0] r_edge;
    logic [WIDTH-1:0] r_mask;
    logic [31:0]      r_readdata;

    logic [WIDTH-1:0] w_stable_nxt;
    logic [CW-1:0]    w_cnt_nxt [WIDTH];
    logic             w_wr;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_edge_set;
    logic [WIDTH-1:0] w_edge_nxt;
    logic [31:0]      w_rd_mux;
    logic             w_unused_wdata;

    // Per-bit debounce: any sample equal to the stable level restarts the
    // count, so only DEBOUNCE_CYCLES consecutive differing samples flip it.
    always_comb begin
        w_stable_nxt = r_stable;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_cnt_nxt[i] = '0;
            if (r_sync2[i] != r_stable[i]) begin
                if (r_cnt[i] == CNT_LAST) begin
                    w_stable_nxt[i] = r_sync2[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_wr  = bus.chipselect && !bus.write_n;
    assign w_clr = (w_wr && (bus.address == ADDR_EDGE)) ? bus.writedata[WIDTH-1:0] : '0;

`ifdef GPIO_COND_FALL_EDGE_EN
    assign w_edge_set = w_stable_nxt ^ r_stable;
`else
    assign w_edge_set = w_stable_nxt & ~r_stable;
`endif

    // Set is OR'd after the clear so a same-cycle set wins over write-1-clear.
    assign w_edge_nxt = (r_edge & ~w_clr) | w_edge_set;

    // Upper writedata bits are don't-care when WIDTH < 32.
    assign w_unused_wdata = |{1'b0, bus.writedata};

    always_comb begin
        w_rd_mux = '0;
        case (bus.address)
            ADDR_STABLE: w_rd_mux[WIDTH-1:0] = r_stable;
            ADDR_EDGE:   w_rd_mux[WIDTH-1:0] = r_edge;
            ADDR_MASK:   w_rd_mux[WIDTH-1:0] = r_mask;
            ADDR_SYNC:   w_rd_mux[WIDTH-1:0] = r_sync2;
            default:     w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_stable   <= '0;
            r_edge     <= '0;
            r_mask     <= '0;
            r_readdata <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1    <= pin_in;
            r_sync2    <= r_sync1;
            r_stable   <= w_stable_nxt;
            r_edge     <= w_edge_nxt;
            r_readdata <= w_rd_mux;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            if (w_wr && (bus.address == ADDR_MASK)) begin
                r_mask <= bus.writedata[WIDTH-1:0];
            end
        end
    end

    assign cond_out     = r_stable;
    assign bus.readdata = r_readdata;
    assign bus.irq      = |(r_edge & r_mask);

endmodule

// File: tb/tb_crypto_wallet_gpio_in_conditioner.sv
// ---------------------------------------------------------------------------
// tb_crypto_wallet_gpio_in_conditioner
//
// Self-checking bench for crypto_wallet_gpio_in_conditioner with WIDTH=4 and
// DEBOUNCE_CYCLES=4. A reference model keeps the history of pin levels seen
// at each clock edge and accepts a new level when the last DEBOUNCE_CYCLES
// synchronised samples all differ from the current stable level.
// ---------------------------------------------------------------------------
module tb_crypto_wallet_gpio_in_conditioner;

    localparam int W  = 4;
    localparam int DC = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] pin_in;
    logic [W-1:0] cond_out;

    crypto_wallet_gpio_in_conditioner_if bus ();

    crypto_wallet_gpio_in_conditioner #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DC)
    ) u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .pin_in   (pin_in),
        .cond_out (cond_out),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [W-1:0] hist [$];
    logic [W-1:0] m_stable;
    logic [W-1:0] m_edge;
    logic [W-1:0] m_mask;
    logic [31:0]  m_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] pin_at(input int idx);
        if (idx < 0 || idx >= hist.size()) return '0;
        return hist[idx];
    endfunction

    task automatic model_reset();
        hist.delete();
        m_stable = '0;
        m_edge   = '0;
        m_mask   = '0;
        m_rd     = '0;
    endtask

    // Called at a rising clock edge with the bench-driven inputs as sampled there.
    task automatic model_edge();
        int           s;
        logic [W-1:0] nxt;
        logic [W-1:0] clr;
        logic [W-1:0] setv;
        logic [W-1:0] v;
        logic         all_diff;
        s   = hist.size();
        nxt = m_stable;
        clr = '0;
        case (bus.address)
            2'd0:    m_rd = 32'(m_stable);
            2'd1:    m_rd = 32'(m_edge);
            2'd2:    m_rd = 32'(m_mask);
            default: m_rd = 32'(pin_at(s - 2));
        endcase
        for (int b = 0; b < W; b++) begin
            all_diff = 1'b1;
            for (int j = s - 1 - DC; j <= s - 2; j++) begin
                v = pin_at(j);
                if (v[b] == m_stable[b]) all_diff = 1'b0;
            end
            if (all_diff) nxt[b] = ~m_stable[b];
        end
        if (bus.chipselect && !bus.write_n) begin
            if (bus.address == 2'd1) clr = bus.writedata[W-1:0];
            if (bus.address == 2'd2) m_mask = bus.writedata[W-1:0];
        end
`ifdef GPIO_COND_FALL_EDGE_EN
        setv = nxt ^ m_stable;
`else
        setv = nxt & ~m_stable;
`endif
        m_edge   = (m_edge & ~clr) | setv;
        m_stable = nxt;
        hist.push_back(pin_in);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("cond_out", 32'(cond_out), 32'(m_stable));
        check("irq", 32'(bus.irq), 32'(|(m_edge & m_mask)));
        check("readdata", bus.readdata, m_rd);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cond_out", 32'(cond_out), 32'h0);
        check("rst_readdata", bus.readdata, 32'h0);
        check("rst_irq", 32'(bus.irq), 32'h0);
        model_reset();
        #1 reset_n = 1'b1;
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        bus.address    = addr;
        bus.writedata  = data;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        pin_in         = '0;
        reset_n        = 1'b1;
        model_reset();
        #1;

        // Reset with all pins high: rising edge appears 6 clks after release
        pin_in = 4'hF;
        apply_reset();
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 5) check("rst_cond_pre", 32'(cond_out), 32'h0);
        end
        check("rst_cond_6", 32'(cond_out), 32'hF);
        bus.address = 2'd1;
        tick();
        check("rst_edge", bus.readdata, 32'hF);

        // Bounce rejection on bit 0
        pin_in = 4'h0;
        apply_reset();
        bus.address = 2'd1;
        repeat (8) tick();
        pin_in = 4'h1;
        repeat (3) tick();
        pin_in = 4'h0;
        tick();
        pin_in = 4'h1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 5) begin
                check("bounce_cond_pre", 32'(cond_out[0]), 32'h0);
                check("bounce_edge_pre", 32'(bus.readdata[0]), 32'h0);
            end
        end
        check("bounce_cond_6", 32'(cond_out[0]), 32'h1);
        tick();
        check("bounce_edge", bus.readdata, 32'h1);

        // IRQ path on bit 1
        bus_write(2'd2, 32'h2);
        pin_in = 4'h3;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 5) check("irq_pre", 32'(bus.irq), 32'h0);
        end
        check("irq_set", 32'(bus.irq), 32'h1);
        bus_write(2'd1, 32'h2);
        check("irq_clr", 32'(bus.irq), 32'h0);
        bus.address = 2'd1;
        tick();
        check("irq_edge_rd", bus.readdata, 32'h1);

        // Set beats clear on bit 2
        pin_in = 4'h7;
        repeat (5) tick();
        bus_write(2'd1, 32'h4);
        bus.address = 2'd1;
        tick();
        check("set_beats_clr", bus.readdata, 32'h5);

        // Readback of all addresses
        bus_write(2'd2, 32'hA);
        bus_write(2'd0, 32'h5);
        bus.address = 2'd0; tick(); check("rb_addr0", bus.readdata, 32'h7);
        bus.address = 2'd1; tick(); check("rb_addr1", bus.readdata, 32'h5);
        bus.address = 2'd2; tick(); check("rb_addr2", bus.readdata, 32'hA);
        bus.address = 2'd3; tick(); check("rb_addr3", bus.readdata, 32'h7);

        // Falling edge on bit 3
        pin_in = 4'hF;
        repeat (8) tick();
        bus_write(2'd1, 32'hF);
        pin_in = 4'h7;
        repeat (6) tick();
        check("fall_cond", 32'(cond_out), 32'h7);
        bus.address = 2'd1;
        tick();
`ifdef GPIO_COND_FALL_EDGE_EN
        check("fall_edge", bus.readdata, 32'h8);
`else
        check("fall_edge", bus.readdata, 32'h0);
`endif

        // Reset mid-debounce aborts the count
        pin_in = 4'h0;
        apply_reset();
        pin_in = 4'hF;
        repeat (4) tick();
        apply_reset();
        bus.address = 2'd1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 5) check("abort_cond_pre", 32'(cond_out), 32'h0);
        end
        check("abort_cond_6", 32'(cond_out), 32'hF);
        check("abort_edge_pre", bus.readdata, 32'h0);

        // Randomised pins and bus traffic against the model
        pin_in = 4'h0;
        apply_reset();
        repeat (1500) begin
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(0, 7) == 0) pin_in[b] = ~pin_in[b];
            end
            bus.address    = 2'($urandom_range(0, 3));
            bus.writedata  = $urandom;
            bus.chipselect = 1'($urandom_range(0, 1));
            bus.write_n    = ($urandom_range(0, 5) != 0);
            tick();
        end
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
